base2_pow_recon: RTL

BASE2_POW_RECON -- requirements
Module: base2_pow_recon

---
 rtl/base2_pow_recon.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/base2_pow_recon.sv
// rtl/base2_pow_recon.sv - three-stage FP16 reconstruction of 2^(k+f) from integer and fractional parts
module base2_pow_recon #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_i,
    input  logic [7:0]    k_i,
    input  logic [DW-1:0] f_i,
    output logic [DW-1:0] y_o,
    output logic          ovf_o,
    output logic          unf_o,
    output logic          valid_o
);

    // 1024 * 2^(i/16), rounded; index 16 closes the last segment at exactly 2.0
    function automatic logic [11:0] seg_base(input logic [4:0] idx);
        case (idx)
            5'd0:    seg_base = 12'd1024;
            5'd1:    seg_base = 12'd1069;
            5'd2:    seg_base = 12'd1117;
            5'd3:    seg_base = 12'd1166;
            5'd4:    seg_base = 12'd1218;
            5'd5:    seg_base = 12'd1272;
            5'd6:    seg_base = 12'd1328;
            5'd7:    seg_base = 12'd1387;
            5'd8:    seg_base = 12'd1448;
            5'd9:    seg_base = 12'd1512;
            5'd10:   seg_base = 12'd1579;
            5'd11:   seg_base = 12'd1649;
            5'd12:   seg_base = 12'd1722;
            5'd13:   seg_base = 12'd1798;
            5'd14:   seg_base = 12'd1878;
            5'd15:   seg_base = 12'd1961;
            default: seg_base = 12'd2048;
        endcase
    endfunction

    // ---------------- stage 1: fraction to Q0.10, carry f>=1 into k
    logic [4:0]  f_exp;
    logic [10:0] f_sig;
    logic [3:0]  f_shamt;
    logic [9:0]  x_next;
    logic        k_inc;
    logic [8:0]  k_next;

    assign f_exp   = f_i[14:10];
    assign f_sig   = {1'b1, f_i[9:0]};
    assign f_shamt = 4'(5'd15 - f_exp);
    assign k_next  = {k_i[7], k_i} + 9'(k_inc);

    // Negative, zero and tiny fractions contribute nothing; f>=1 (incl. inf/NaN) becomes a k carry
    always_comb begin
        x_next = '0;
        k_inc  = 1'b0;
        if (f_i[15] || (f_i == '0) || (f_exp < 5'd5)) begin
            x_next = '0;
        end else if (f_exp >= 5'd15) begin
            k_inc = 1'b1;
        end else begin
            x_next = 10'(f_sig >> f_shamt);
        end
    end

    logic       s1_valid;
    logic [9:0] s1_x;
    logic [8:0] s1_k;

    // Stage 1 registers: data loads every cycle, valid bit qualifies it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_k     <= '0;
        end else begin
            s1_valid <= valid_i;
            s1_x     <= x_next;
            s1_k     <= k_next;
        end
    end

    // ---------------- stage 2: piecewise-linear 2^x mantissa
    logic [3:0]  seg_i;
    logic [5:0]  seg_d;
    logic [11:0] base_lo;
    logic [11:0] slope;
    logic [17:0] prod;
    logic [11:0] incr;
    logic [11:0] m_full;
    logic [9:0]  m_frac;

    assign seg_i   = s1_x[9:6];
    assign seg_d   = s1_x[5:0];
    assign base_lo = seg_base({1'b0, seg_i});
    assign slope   = seg_base({1'b0, seg_i} + 5'd1) - base_lo;
    assign prod    = 18'(slope) * 18'(seg_d);
    assign incr    = 12'((prod + 18'd32) >> 6);
    assign m_full  = base_lo + incr;
    // Hidden bit is implicit; saturate to the largest 11-bit mantissa
    assign m_frac  = (m_full > 12'd2047) ? 10'h3FF : m_full[9:0];

    logic       s2_valid;
    logic [9:0] s2_m;
    logic [8:0] s2_k;

    // Stage 2 registers: mantissa fraction and carried k
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_m     <= '0;
            s2_k     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_m     <= m_frac;
            s2_k     <= s1_k;
        end
    end

    // ---------------- stage 3: exponent bias, saturate/flush, output hold
    logic signed [9:0] e_biased;

    assign e_biased = $signed({s2_k[8], s2_k}) + 10'sd15;

    // Outputs change only for a valid sample and otherwise keep their last value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_o <= 1'b0;
            y_o     <= '0;
            ovf_o   <= 1'b0;
            unf_o   <= 1'b0;
        end else begin
            valid_o <= s2_valid;
            if (s2_valid) begin
                if (e_biased >= 10'sd31) begin
                    y_o   <= 16'h7C00;
                    ovf_o <= 1'b1;
                    unf_o <= 1'b0;
                end else if (e_biased <= 10'sd0) begin
                    y_o   <= 16'h0000;
                    ovf_o <= 1'b0;
                    unf_o <= 1'b1;
                end else begin
                    y_o   <= {1'b0, e_biased[4:0], s2_m};
                    ovf_o <= 1'b0;
                    unf_o <= 1'b0;
                end
            end
        end
    end

endmodule
